// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_scan block.
package decoder_pkg;

  // Controller states: waiting for a request, holding one line, sweeping all lines.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Values of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational N-to-2**N one-hot decoder.
module onehot_dec #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      sel,
  output logic [(2**IN_W)-1:0] lines
);

  localparam int OUT_W = 2 ** IN_W;

  // Each output line compares the select against its own index.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
      assign lines[gi] = (sel == IN_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_scan.sv
// Decoder with timed hold: drives one registered line for HOLD_CYC cycles,
// either a single selected line or a wrapping sweep over every line.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int HOLD_CYC   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [IN_W-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [(2**IN_W)-1:0]  out,
  output logic                  out_valid,
  output logic                  done
);

  localparam int OUT_W  = 2 ** IN_W;
  localparam int CNT_W  = $clog2(HOLD_CYC) + 1;
  localparam int STEP_W = IN_W + 1;

  // XOR mask that turns a one-hot vector into the output polarity; it is
  // also the pattern driven when no line is asserted.
  localparam logic [OUT_W-1:0]  INACTIVE  = {OUT_W{(ACTIVE_LOW != 0)}};
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(OUT_W - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cyc_reg;
  logic [STEP_W-1:0]  step_reg;
  logic [IN_W-1:0]    idx_reg;
  logic [OUT_W-1:0]   out_reg;
  logic               out_valid_reg;
  logic               done_reg;

  logic [IN_W-1:0]    idx_next;
  logic [IN_W-1:0]    dec_sel;
  logic [OUT_W-1:0]   dec_lines;
  logic [OUT_W-1:0]   dec_pat;
  logic               accept;

  // Natural wrap of the IN_W-bit index gives the OUT_W-1 -> 0 rollover.
  assign idx_next = idx_reg + IN_W'(1);

  // One decoder serves both the accept edge (in_sel) and scan steps (next index).
  assign dec_sel = (state_reg == ST_SCAN) ? idx_next : in_sel;

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .sel   (dec_sel),
    .lines (dec_lines)
  );

  assign dec_pat  = dec_lines ^ INACTIVE;
  assign in_ready = (state_reg == ST_IDLE) && en;
  assign accept   = in_valid && in_ready;

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;

  // Controller: accepts requests, times each line, sweeps indices and aborts on en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cyc_reg       <= '0;
      step_reg      <= '0;
      idx_reg       <= '0;
      out_reg       <= INACTIVE;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          out_reg       <= INACTIVE;
          out_valid_reg <= 1'b0;
          if (accept) begin
            out_reg       <= dec_pat;
            out_valid_reg <= 1'b1;
            cyc_reg       <= '0;
            step_reg      <= '0;
            idx_reg       <= in_sel;
            state_reg     <= (mode == MODE_SCAN) ? ST_SCAN : ST_HOLD;
          end
        end
        ST_HOLD, ST_SCAN: begin
          if (!en) begin
            // Abort: drop the line at once and return without a done pulse.
            out_reg       <= INACTIVE;
            out_valid_reg <= 1'b0;
            cyc_reg       <= '0;
            step_reg      <= '0;
            state_reg     <= ST_IDLE;
          end else if (cyc_reg != CYC_LAST) begin
            cyc_reg <= cyc_reg + CNT_W'(1);
          end else if (state_reg == ST_SCAN && step_reg != STEP_LAST) begin
            // Move straight to the next line so no inactive cycle appears between steps.
            step_reg <= step_reg + STEP_W'(1);
            idx_reg  <= idx_next;
            cyc_reg  <= '0;
            out_reg  <= dec_pat;
          end else begin
            out_reg       <= INACTIVE;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
            cyc_reg       <= '0;
            step_reg      <= '0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_reg       <= INACTIVE;
          out_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (HOLD_CYC=4 active-high, HOLD_CYC=1
// active-low), a timeline model per instance and directed request sequences.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_en, a_mode, a_valid, a_ready, a_ov, a_done;
  logic [2:0] a_sel;
  logic [7:0] a_out;
  logic       b_en, b_mode, b_valid, b_ready, b_ov, b_done;
  logic [2:0] b_sel;
  logic [7:0] b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan #(.IN_W(3), .HOLD_CYC(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ready), .out(a_out), .out_valid(a_ov),
    .done(a_done)
  );

  decoder_scan #(.IN_W(3), .HOLD_CYC(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ready), .out(b_out), .out_valid(b_ov),
    .done(b_done)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Line expected t cycles after the accept edge, for hold length h.
  function automatic logic [7:0] line_at(int sel, int t, int h, bit al);
    logic [7:0] v;
    v = 8'h01 << ((sel + t / h) % 8);
    return al ? ~v : v;
  endfunction

  function automatic int total_cycles(bit scan, int h);
    return scan ? 8 * h : h;
  endfunction

  // Model A: request remembered as (start, mode, elapsed cycles).
  bit         ma_act = 1'b0, ma_scan = 1'b0;
  int         ma_sel = 0, ma_t = 0;
  logic [7:0] ma_out = 8'h00;
  logic       ma_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_act <= 1'b0; ma_out <= 8'h00; ma_done <= 1'b0;
    end else begin
      ma_done <= 1'b0;
      ma_out  <= 8'h00;
      if (ma_act) begin
        if (!a_en) ma_act <= 1'b0;
        else if (ma_t + 1 >= total_cycles(ma_scan, 4)) begin
          ma_act <= 1'b0; ma_done <= 1'b1;
        end else begin
          ma_t <= ma_t + 1; ma_out <= line_at(ma_sel, ma_t + 1, 4, 1'b0);
        end
      end else if (a_en && a_valid) begin
        ma_act <= 1'b1; ma_sel <= int'(a_sel); ma_scan <= a_mode; ma_t <= 0;
        ma_out <= line_at(int'(a_sel), 0, 4, 1'b0);
      end
    end
  end

  // Model B: same rules, hold of one cycle and inverted polarity.
  bit         mb_act = 1'b0, mb_scan = 1'b0;
  int         mb_sel = 0, mb_t = 0;
  logic [7:0] mb_out = 8'hFF;
  logic       mb_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_act <= 1'b0; mb_out <= 8'hFF; mb_done <= 1'b0;
    end else begin
      mb_done <= 1'b0;
      mb_out  <= 8'hFF;
      if (mb_act) begin
        if (!b_en) mb_act <= 1'b0;
        else if (mb_t + 1 >= total_cycles(mb_scan, 1)) begin
          mb_act <= 1'b0; mb_done <= 1'b1;
        end else begin
          mb_t <= mb_t + 1; mb_out <= line_at(mb_sel, mb_t + 1, 1, 1'b1);
        end
      end else if (b_en && b_valid) begin
        mb_act <= 1'b1; mb_sel <= int'(b_sel); mb_scan <= b_mode; mb_t <= 0;
        mb_out <= line_at(int'(b_sel), 0, 1, 1'b1);
      end
    end
  end

  // Every falling edge: all outputs of both instances against their models.
  always @(negedge clk) begin
    chk("a_out", a_out, ma_out);
    chk("a_out_valid", {7'b0, a_ov}, {7'b0, ma_out != 8'h00});
    chk("a_done", {7'b0, a_done}, {7'b0, ma_done});
    chk("a_in_ready", {7'b0, a_ready}, {7'b0, !ma_act && a_en});
    chk("b_out", b_out, mb_out);
    chk("b_out_valid", {7'b0, b_ov}, {7'b0, mb_out != 8'hFF});
    chk("b_done", {7'b0, b_done}, {7'b0, mb_done});
    chk("b_in_ready", {7'b0, b_ready}, {7'b0, !mb_act && b_en});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [7:0] scan_a [8];
  logic [7:0] scan_b [8];

  initial begin
    scan_a = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    scan_b = '{8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE, 8'hFD, 8'hFB};
    a_en = 1'b1; a_mode = 1'b0; a_valid = 1'b0; a_sel = 3'd0;
    b_en = 1'b1; b_mode = 1'b0; b_valid = 1'b0; b_sel = 3'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Idle after reset.
    chk("rst_out", a_out, 8'h00);
    chk("rst_ready", {7'b0, a_ready}, 8'h01);
    chk("rst_done", {7'b0, a_done}, 8'h00);
    $display("txn reset: a_out=%h b_out=%h", a_out, b_out);

    // Direct decode of 5.
    a_mode = 1'b0; a_sel = 3'b101; a_valid = 1'b1;
    cyc(1);
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("dir_out", a_out, 8'h20);
      chk("dir_ready", {7'b0, a_ready}, 8'h00);
      cyc(1);
    end
    chk("dir_end_out", a_out, 8'h00);
    chk("dir_done", {7'b0, a_done}, 8'h01);
    cyc(1);
    chk("dir_done_clr", {7'b0, a_done}, 8'h00);
    $display("txn direct sel=5 done");

    // Full scan from 6, with an ignored request mid-sweep.
    a_mode = 1'b1; a_sel = 3'b110; a_valid = 1'b1;
    cyc(1);
    a_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("scan_out", a_out, scan_a[k / 4]);
      if (k == 5) begin a_valid = 1'b1; a_mode = 1'b0; a_sel = 3'd0; end
      if (k == 6) a_valid = 1'b0;
      cyc(1);
    end
    chk("scan_end_out", a_out, 8'h00);
    chk("scan_done", {7'b0, a_done}, 8'h01);
    cyc(1);
    $display("txn scan sel=6 done");

    // Scan from 2, en dropped during the third step.
    a_mode = 1'b1; a_sel = 3'd2; a_valid = 1'b1;
    cyc(1);
    a_valid = 1'b0;
    cyc(9);
    chk("abort_pre_out", a_out, 8'h10);
    a_en = 1'b0;
    cyc(1);
    chk("abort_out", a_out, 8'h00);
    chk("abort_done", {7'b0, a_done}, 8'h00);
    a_en = 1'b1;
    #1;
    chk("abort_idle_ready", {7'b0, a_ready}, 8'h01);
    cyc(1);
    chk("abort_no_done", {7'b0, a_done}, 8'h00);
    $display("txn scan abort done");

    // Asynchronous reset mid-scan, then accept on the first edge after release.
    a_mode = 1'b1; a_sel = 3'd0; a_valid = 1'b1;
    cyc(1);
    a_valid = 1'b0;
    cyc(5);
    chk("rstmid_pre_out", a_out, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out", a_out, 8'h00);
    chk("rstmid_valid", {7'b0, a_ov}, 8'h00);
    chk("rstmid_done", {7'b0, a_done}, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    a_mode = 1'b0; a_sel = 3'd2; a_valid = 1'b1;
    cyc(1);
    a_valid = 1'b0;
    chk("post_rst_out", a_out, 8'h04);
    cyc(4);
    chk("post_rst_done", {7'b0, a_done}, 8'h01);
    cyc(1);
    $display("txn reset mid-scan done");

    // Single-cycle hold, active-low: direct 0.
    b_mode = 1'b0; b_sel = 3'd0; b_valid = 1'b1;
    cyc(1);
    b_valid = 1'b0;
    chk("b_dir_out", b_out, 8'hFE);
    chk("b_dir_valid", {7'b0, b_ov}, 8'h01);
    cyc(1);
    chk("b_dir_end_out", b_out, 8'hFF);
    chk("b_dir_done", {7'b0, b_done}, 8'h01);
    chk("b_dir_end_valid", {7'b0, b_ov}, 8'h00);
    cyc(1);
    $display("txn b direct sel=0 done");

    // Single-cycle scan from 3, then a new request accepted in the done cycle.
    b_mode = 1'b1; b_sel = 3'd3; b_valid = 1'b1;
    cyc(1);
    b_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b_scan_out", b_out, scan_b[k]);
      cyc(1);
    end
    chk("b_scan_done", {7'b0, b_done}, 8'h01);
    b_mode = 1'b0; b_sel = 3'd7; b_valid = 1'b1;
    cyc(1);
    b_valid = 1'b0;
    chk("b_b2b_out", b_out, 8'h7F);
    cyc(3);
    $display("txn b scan sel=3 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
